intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_if.sv | 22 ++
 rtl/intr_ctrl.sv | 136 +++++++++++++
 tb/tb_intr_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/intr_ctrl_if.sv
// Register bus between the device bridge and the interrupt controller.
// The bridge drives address, write strobe and data; the controller returns read data.
interface intr_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (
        output addr,
        output we,
        output din,
        input  dout
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout
    );
endinterface

// File: rtl/intr_ctrl.sv
// Six-source prioritised interrupt controller with PEND/MASK/VEC/ISR registers.
// INTR_EDGE_EN selects edge-triggered pending with W1C; default is level-sensitive.
module intr_ctrl #(
    parameter logic [5:0] RESET_MASK = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hwint,
    intr_ctrl_if.slave  bus,
    output logic        irq,
    output logic [2:0]  irqvec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_INSVC
    } state_t;

    state_t     r_state;
    logic       r_irq;
    logic [2:0] r_irqvec;
    logic [5:0] r_pend;
    logic [5:0] r_mask;
    logic [5:0] r_isr;

    logic       w_wr_mask;
    logic       w_ack_fire;
    logic       w_eoi_fire;
    logic [5:0] w_elig;
    logic [5:0] w_vec_oh;
    logic [5:0] w_pend_nxt;
    logic [2:0] w_win;
    logic       w_any;
    logic       w_drop;
    logic       w_unused;

    assign w_wr_mask  = bus.we && (bus.addr == 2'd1);
    assign w_ack_fire = bus.we && (bus.addr == 2'd2) && (r_state == S_REQ);
    assign w_eoi_fire = bus.we && (bus.addr == 2'd3) && (r_state == S_INSVC);
    assign w_elig     = r_pend & r_mask;
    assign w_any      = |w_elig;
    assign w_vec_oh   = 6'b000001 << r_irqvec;
    assign w_drop     = ((r_pend & w_vec_oh) == 6'h00) ||
                        ((r_mask & w_vec_oh) == 6'h00);
    assign w_unused   = &{1'b0, bus.din[31:6]};

    always_comb begin
        w_win = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_elig[i]) w_win = 3'(i);
        end
    end

`ifdef INTR_EDGE_EN
    logic [5:0] r_hist;
    logic       w_wr_pend;
    logic [5:0] w_rise;
    logic [5:0] w_clr;

    assign w_wr_pend  = bus.we && (bus.addr == 2'd0);
    assign w_rise     = hwint & ~r_hist;
    assign w_clr      = (w_wr_pend ? bus.din[5:0] : 6'h00) |
                        (w_ack_fire ? w_vec_oh : 6'h00);
    // a fresh edge beats any clear landing on the same bit
    assign w_pend_nxt = (r_pend & ~w_clr) | w_rise;

    always_ff @(posedge clk) begin
        if (reset) r_hist <= 6'h00;
        else       r_hist <= hwint;
    end
`else
    assign w_pend_nxt = hwint;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 6'h00;
            r_mask <= RESET_MASK;
            r_isr  <= 6'h00;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr_mask) r_mask <= bus.din[5:0];
            if (w_eoi_fire)      r_isr <= 6'h00;
            else if (w_ack_fire) r_isr <= r_isr | w_vec_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_irq    <= 1'b0;
            r_irqvec <= 3'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state  <= S_REQ;
                        r_irqvec <= w_win;
                        r_irq    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_ack_fire) begin
                        r_state <= S_INSVC;
                        r_irq   <= 1'b0;
                    end else if (w_drop) begin
                        r_state <= S_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                S_INSVC: begin
                    if (w_eoi_fire) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.dout = 32'h0;
        case (bus.addr)
            2'd0:    bus.dout = {26'h0, r_pend};
            2'd1:    bus.dout = {26'h0, r_mask};
            2'd2:    bus.dout = {r_irq, 28'h0, r_irqvec};
            default: bus.dout = {26'h0, r_isr};
        endcase
    end

    assign irq    = r_irq;
    assign irqvec = r_irqvec;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed table-driven bench for intr_ctrl; expectations cover both the
// edge-triggered (INTR_EDGE_EN) and level-sensitive builds.
module tb_intr_ctrl;

`ifdef INTR_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] hwint;
    logic       irq;
    logic [2:0] irqvec;

    intr_ctrl_if bus ();

    intr_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .hwint  (hwint),
        .bus    (bus),
        .irq    (irq),
        .irqvec (irqvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [5:0]  hw;
        logic        irq;
        logic [2:0]  vec;
        logic [5:0]  pe;
        logic [5:0]  pl;
        logic [5:0]  isr;
        logic [5:0]  mask;
    } vec_t;

    int n_cmp;
    int n_bad;

    vec_t tv [34];

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [1:0] addr,
        input logic [31:0] din, input logic [5:0] hw,
        input logic ei, input logic [2:0] ev, input logic [5:0] pe,
        input logic [5:0] pl, input logic [5:0] isr, input logic [5:0] mask);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.din = din; v.hw = hw;
        v.irq = ei; v.vec = ev; v.pe = pe; v.pl = pl;
        v.isr = isr; v.mask = mask;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic ei, input logic [2:0] ev,
                             input logic [5:0] ep, input logic [5:0] eisr,
                             input logic [5:0] emask);
        bus.addr = 2'd0; #1;
        chk("pend", idx, bus.dout, {26'h0, ep});
        bus.addr = 2'd1; #1;
        chk("mask", idx, bus.dout, {26'h0, emask});
        bus.addr = 2'd3; #1;
        chk("isr", idx, bus.dout, {26'h0, eisr});
        bus.addr = 2'd2; #1;
        chk("vec_rd", idx, bus.dout, {ei, 28'h0, ev});
        chk("irq", idx, {31'h0, irq}, {31'h0, ei});
        chk("irqvec", idx, {29'h0, irqvec}, {29'h0, ev});
    endtask

    task automatic drive(input logic rst, input logic we, input logic [1:0] addr,
                         input logic [31:0] din, input logic [5:0] hw);
        reset    = rst;
        bus.we   = we;
        bus.addr = addr;
        bus.din  = din;
        hwint    = hw;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.we = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 32'h0;
        hwint    = 6'h00;

        //         rst we ad din        hw     irq vec pe     pl     isr    mask
        tv[0]  = mk(1, 0, 0, 32'h0,     6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
        tv[1]  = mk(0, 1, 1, 32'h3,     6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h03);
        tv[2]  = mk(0, 0, 0, 32'h0,     6'h02, 0, 0, 6'h02, 6'h02, 6'h00, 6'h03);
        tv[3]  = mk(0, 0, 0, 32'h0,     6'h02, 1, 1, 6'h02, 6'h02, 6'h00, 6'h03);
        tv[4]  = mk(0, 1, 2, 32'h0,     6'h02, 0, 1, 6'h00, 6'h02, 6'h02, 6'h03);
        tv[5]  = mk(0, 1, 3, 32'h0,     6'h00, 0, 1, 6'h00, 6'h00, 6'h00, 6'h03);
        tv[6]  = mk(0, 0, 0, 32'h0,     6'h00, 0, 1, 6'h00, 6'h00, 6'h00, 6'h03);
        tv[7]  = mk(0, 0, 0, 32'h0,     6'h03, 0, 1, 6'h03, 6'h03, 6'h00, 6'h03);
        tv[8]  = mk(0, 0, 0, 32'h0,     6'h03, 1, 0, 6'h03, 6'h03, 6'h00, 6'h03);
        tv[9]  = mk(0, 1, 2, 32'h0,     6'h03, 0, 0, 6'h02, 6'h03, 6'h01, 6'h03);
        tv[10] = mk(0, 1, 3, 32'h0,     6'h02, 0, 0, 6'h02, 6'h02, 6'h00, 6'h03);
        tv[11] = mk(0, 0, 0, 32'h0,     6'h02, 1, 1, 6'h02, 6'h02, 6'h00, 6'h03);
        tv[12] = mk(0, 1, 3, 32'h0,     6'h03, 1, 1, 6'h03, 6'h03, 6'h00, 6'h03);
        tv[13] = mk(0, 1, 2, 32'h0,     6'h03, 0, 1, 6'h01, 6'h03, 6'h02, 6'h03);
        tv[14] = mk(0, 1, 2, 32'h0,     6'h03, 0, 1, 6'h01, 6'h03, 6'h02, 6'h03);
        tv[15] = mk(0, 1, 3, 32'h0,     6'h01, 0, 1, 6'h01, 6'h01, 6'h00, 6'h03);
        tv[16] = mk(0, 0, 0, 32'h0,     6'h01, 1, 0, 6'h01, 6'h01, 6'h00, 6'h03);
        tv[17] = mk(0, 1, 2, 32'h0,     6'h01, 0, 0, 6'h00, 6'h01, 6'h01, 6'h03);
        tv[18] = mk(0, 1, 3, 32'h0,     6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h03);
        tv[19] = mk(0, 0, 0, 32'h0,     6'h02, 0, 0, 6'h02, 6'h02, 6'h00, 6'h03);
        tv[20] = mk(0, 0, 0, 32'h0,     6'h02, 1, 1, 6'h02, 6'h02, 6'h00, 6'h03);
        tv[21] = mk(0, 1, 1, 32'h0,     6'h02, 1, 1, 6'h02, 6'h02, 6'h00, 6'h00);
        tv[22] = mk(0, 0, 0, 32'h0,     6'h02, 0, 1, 6'h02, 6'h02, 6'h00, 6'h00);
        tv[23] = mk(0, 1, 1, 32'h3F,    6'h02, 0, 1, 6'h02, 6'h02, 6'h00, 6'h3F);
        tv[24] = mk(0, 0, 0, 32'h0,     6'h02, 1, 1, 6'h02, 6'h02, 6'h00, 6'h3F);
        tv[25] = mk(0, 1, 2, 32'h0,     6'h02, 0, 1, 6'h00, 6'h02, 6'h02, 6'h3F);
        tv[26] = mk(1, 1, 3, 32'h0,     6'h02, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
        tv[27] = mk(0, 0, 0, 32'h0,     6'h02, 0, 0, 6'h02, 6'h02, 6'h00, 6'h00);
        tv[28] = mk(0, 0, 0, 32'h0,     6'h00, 0, 0, 6'h02, 6'h00, 6'h00, 6'h00);
        tv[29] = mk(0, 1, 0, 32'h4,     6'h04, 0, 0, 6'h06, 6'h04, 6'h00, 6'h00);
        tv[30] = mk(0, 1, 0, 32'h6,     6'h04, 0, 0, 6'h00, 6'h04, 6'h00, 6'h00);
        tv[31] = mk(0, 0, 0, 32'h0,     6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
        tv[32] = mk(0, 1, 2, 32'h0,     6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
        tv[33] = mk(0, 1, 3, 32'h0,     6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);

        for (int i = 0; i < 34; i++) begin
            drive(tv[i].rst, tv[i].we, tv[i].addr, tv[i].din, tv[i].hw);
            check_all(i, tv[i].irq, tv[i].vec,
                      EDGE ? tv[i].pe : tv[i].pl, tv[i].isr, tv[i].mask);
        end

        // single-cycle pulse on source 1: held by PEND only in the edge build
        drive(0, 1, 2'd1, 32'h3, 6'h00);
        check_all(100, 0, 0, 6'h00, 6'h00, 6'h03);
        drive(0, 0, 2'd0, 32'h0, 6'h02);
        check_all(101, 0, 0, 6'h02, 6'h00, 6'h03);
        drive(0, 0, 2'd0, 32'h0, 6'h00);
        check_all(102, 1, 1, EDGE ? 6'h02 : 6'h00, 6'h00, 6'h03);
        drive(0, 0, 2'd0, 32'h0, 6'h00);
        check_all(103, EDGE, 1, EDGE ? 6'h02 : 6'h00, 6'h00, 6'h03);
        drive(0, 1, 2'd2, 32'h0, 6'h00);
        check_all(104, 0, 1, 6'h00, EDGE ? 6'h02 : 6'h00, 6'h03);
        drive(0, 1, 2'd3, 32'h0, 6'h00);
        check_all(105, 0, 1, 6'h00, 6'h00, 6'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
